// File: rtl/instr_packer_pkg.sv
// Shared instruction-types package: immediate-format select plus the packer's request, word and buffer types.
// The fits_signed helper backs the optional INSTR_PACKER_RANGE_CHECK_EN immediate range check.
package instr_packer_pkg;

    typedef enum logic [2:0] {
        IMMGEN_I  = 3'd0,
        IMMGEN_S  = 3'd1,
        IMMGEN_SB = 3'd2,
        IMMGEN_UJ = 3'd3,
        IMMGEN_U  = 3'd4
    } immgen_t;

    typedef struct packed {
        immgen_t     imm_sel;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } pack_req_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } pack_word_t;

    localparam int PACK_DEPTH = 2;

    // True when v equals the sign-extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] ext;
        for (int b = 0; b < 32; b++) begin
            ext[b] = (b < int'(bits)) ? v[b] : v[bits-1];
        end
        return (ext == v);
    endfunction

endpackage

// File: rtl/instr_pack_comb.sv
// Pure combinational scatter of a 32-bit immediate into the RISC-V format fields.
// With INSTR_PACKER_RANGE_CHECK_EN defined, unrepresentable immediates also raise err.
module instr_pack_comb
    import instr_packer_pkg::*;
(
    input  pack_req_t   req,
    output logic [31:0] instr,
    output logic        err
);

    logic [31:0] imm;
    logic        sel_ok;

    assign imm = req.imm;

    always_comb begin
        instr  = '0;
        sel_ok = 1'b1;
        case (req.imm_sel)
            IMMGEN_I:  instr = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            IMMGEN_S:  instr = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
            IMMGEN_SB: instr = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                                imm[4:1], imm[11], req.opcode};
            IMMGEN_UJ: instr = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
            IMMGEN_U:  instr = {imm[31:12], req.rd, req.opcode};
            default: begin
                instr  = '0;
                sel_ok = 1'b0;
            end
        endcase
    end

`ifdef INSTR_PACKER_RANGE_CHECK_EN
    logic range_ok;

    // Packing proceeds unchanged; this only flags immediates the format cannot hold.
    always_comb begin
        range_ok = 1'b1;
        case (req.imm_sel)
            IMMGEN_I, IMMGEN_S: range_ok = fits_signed(imm, 12);
            IMMGEN_SB:          range_ok = fits_signed(imm, 13) && !imm[0];
            IMMGEN_UJ:          range_ok = fits_signed(imm, 21) && !imm[0];
            IMMGEN_U:           range_ok = (imm[11:0] == 12'h000);
            default:            range_ok = 1'b1;
        endcase
    end

    assign err = !sel_ok || !range_ok;
`else
    assign err = !sel_ok;
`endif

endmodule

// File: rtl/instr_packer.sv
// Instruction packer: valid/ready request in, packed 32-bit instruction out through a 2-entry FIFO.
// Optional INSTR_PACKER_RANGE_CHECK_EN enables immediate range flagging in instr_pack_comb.
module instr_packer
    import instr_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  immgen_t     imm_sel,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    if (DEPTH != PACK_DEPTH) begin : g_depth_check
        $error("instr_packer: DEPTH must be 2");
    end

    buf_state_t       state_reg, state_next;
    pack_word_t       slot_reg  [DEPTH];
    pack_word_t       slot_next [DEPTH];
    pack_word_t       packed_word;
    pack_req_t        req;
    logic [31:0]      pack_instr;
    logic             pack_err;
    logic             accept, drain;
    logic [DEPTH-1:0] load_new, load_shift;

    assign req = '{imm_sel: imm_sel, opcode: opcode, rd: rd, rs1: rs1,
                   rs2: rs2, funct3: funct3, imm: imm};

    instr_pack_comb u_pack (
        .req   (req),
        .instr (pack_instr),
        .err   (pack_err)
    );

    assign packed_word = '{err: pack_err, instr: pack_instr};

    assign in_ready  = (state_reg != BUF_FULL);
    assign out_valid = (state_reg != BUF_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Slot 0 is always the head; a new word lands in the first slot that is free after any drain.
    always_comb begin
        state_next = state_reg;
        load_new   = '0;
        load_shift = '0;
        case (state_reg)
            BUF_EMPTY: begin
                if (accept) begin
                    state_next  = BUF_ONE;
                    load_new[0] = 1'b1;
                end
            end
            BUF_ONE: begin
                case ({accept, drain})
                    2'b10: begin
                        state_next  = BUF_FULL;
                        load_new[1] = 1'b1;
                    end
                    2'b01: state_next = BUF_EMPTY;
                    2'b11: begin
                        state_next  = BUF_ONE;
                        load_new[0] = 1'b1;
                    end
                    default: state_next = BUF_ONE;
                endcase
            end
            BUF_FULL: begin
                if (drain) begin
                    state_next    = BUF_ONE;
                    load_shift[0] = 1'b1;
                end
            end
            default: state_next = BUF_EMPTY;
        endcase
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        pack_word_t shift_src;
        if (gi < DEPTH - 1) begin : g_mid
            assign shift_src = slot_reg[gi+1];
        end else begin : g_last
            assign shift_src = '0;
        end
        assign slot_next[gi] = load_new[gi]   ? packed_word :
                               load_shift[gi] ? shift_src   : slot_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BUF_EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= slot_next[i];
            end
        end
    end

    assign out_instr = slot_reg[0].instr;
    assign out_err   = slot_reg[0].err;

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: directed scenarios plus randomized traffic against a queue model.
// Expectations follow INSTR_PACKER_RANGE_CHECK_EN when it is defined for the build.
module tb_instr_packer;
    import instr_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    immgen_t     imm_sel = IMMGEN_I;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_packer #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_sel   (imm_sel),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    // Representability of an immediate, expressed as numeric ranges.
    function automatic logic model_range_ok(input logic [2:0] s, input logic [31:0] im);
        int si;
        si = $signed(im);
        case (s)
            3'd0, 3'd1: return (si >= -2048) && (si <= 2047);
            3'd2:       return (si >= -4096) && (si <= 4095) && (im % 2 == 0);
            3'd3:       return (si >= -1048576) && (si <= 1048575) && (im % 2 == 0);
            3'd4:       return (im % 4096 == 0);
            default:    return 1'b1;
        endcase
    endfunction

    // Expected {err, instr} built with shifts and masks field by field.
    function automatic logic [32:0] model_pack(input logic [2:0] s, input logic [6:0] op,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [2:0] f3,
                                               input logic [31:0] im);
        logic [31:0] w;
        logic        e;
        logic [31:0] dd, r1, r2, ff;
        dd = 32'(d) << 7;
        ff = 32'(f3) << 12;
        r1 = 32'(s1) << 15;
        r2 = 32'(s2) << 20;
        case (s)
            3'd0: w = 32'(op) | dd | ff | r1 | ((im & 32'hFFF) << 20);
            3'd1: w = 32'(op) | ((im & 32'h1F) << 7) | ff | r1 | r2 | (((im >> 5) & 32'h7F) << 25);
            3'd2: w = 32'(op) | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8) | ff | r1 | r2
                      | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
            3'd3: w = 32'(op) | dd | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
                      | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
            3'd4: w = 32'(op) | dd | (im & 32'hFFFFF000);
            default: return {1'b1, 32'h0};
        endcase
`ifdef INSTR_PACKER_RANGE_CHECK_EN
        e = !model_range_ok(s, im);
`else
        e = 1'b0;
`endif
        return {e, w};
    endfunction

    // Decode-stage immediate generator, used to confirm the round trip.
    function automatic logic [31:0] immgen(input logic [2:0] s, input logic [31:0] w);
        case (s)
            3'd0:    return {{20{w[31]}}, w[31:20]};
            3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return {w[31:12], 12'h000};
        endcase
    endfunction

    task automatic set_req(input logic [2:0] s, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [31:0] im);
        imm_sel = immgen_t'(s);
        opcode  = op;
        rd      = d;
        rs1     = s1;
        rs2     = s2;
        funct3  = f3;
        imm     = im;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err got %b want 0", out_err); end
        $display("[TB] reset checked");
    endtask

    task automatic test_latency();
        @(negedge clk);
        out_ready = 1'b1;
        set_req(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL latency_valid got %b want 1", out_valid); end
        tests++; if (out_instr !== 32'h00500093) begin fails++; $display("FAIL latency_instr got %h want 00500093", out_instr); end
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL latency_err got %b want 0", out_err); end
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_drain got %b want 0", out_valid); end
        $display("[TB] latency addi -> %h", 32'h00500093);
    endtask

    task automatic test_formats();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0020A423;
        exp_w[1] = 32'hFE000EE3;
        exp_w[2] = 32'h001000EF;
        exp_w[3] = 32'h123452B7;
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            in_valid = (i < 4);
            case (i)
                0: set_req(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
                1: set_req(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC);
                2: set_req(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
                3: set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
                default: ;
            endcase
            #1;
            if (i > 0) begin
                tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fmt%0d_valid got %b want 1", i-1, out_valid); end
                tests++; if (out_instr !== exp_w[i-1]) begin fails++; $display("FAIL fmt%0d_instr got %h want %h", i-1, out_instr, exp_w[i-1]); end
                tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL fmt%0d_err got %b want 0", i-1, out_err); end
                $display("[TB] format %0d -> %h", i-1, out_instr);
            end
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fmt%0d_in_ready got %b want 1", i, in_ready); end
        end
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fmt_end_valid got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [32:0] w0, w1, w2;
        w0 = model_pack(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'hFFFFFFF0);
        w1 = model_pack(3'd1, 7'h23, 5'd0, 5'd6, 5'd7, 3'd2, 32'd100);
        w2 = model_pack(3'd4, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 32'hABCDE000);
        @(negedge clk);
        out_ready = 1'b0;
        set_req(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'hFFFFFFF0);
        in_valid = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready0 got %b want 1", in_ready); end
        @(negedge clk);
        set_req(3'd1, 7'h23, 5'd0, 5'd6, 5'd7, 3'd2, 32'd100);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        tests++; if (out_instr !== w0[31:0]) begin fails++; $display("FAIL bp_head1 got %h want %h", out_instr, w0[31:0]); end
        @(negedge clk);
        set_req(3'd4, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 32'hABCDE000);
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got %b want 0", in_ready); end
        tests++; if (out_instr !== w0[31:0]) begin fails++; $display("FAIL bp_stall2 got %h want %h", out_instr, w0[31:0]); end
        @(negedge clk);
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full3 got %b want 0", in_ready); end
        tests++; if (out_instr !== w0[31:0] || out_err !== w0[32]) begin fails++; $display("FAIL bp_stall3 got %h/%b want %h/%b", out_instr, out_err, w0[31:0], w0[32]); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        tests++; if (out_instr !== w0[31:0]) begin fails++; $display("FAIL bp_out0 got %h want %h", out_instr, w0[31:0]); end
        @(negedge clk);
        #1;
        tests++; if (out_instr !== w1[31:0] || out_err !== w1[32]) begin fails++; $display("FAIL bp_out1 got %h want %h", out_instr, w1[31:0]); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b1 || out_instr !== w2[31:0]) begin fails++; $display("FAIL bp_out2 got %b/%h want 1/%h", out_valid, out_instr, w2[31:0]); end
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", out_valid); end
        $display("[TB] backpressure drained %h %h %h", w0[31:0], w1[31:0], w2[31:0]);
    endtask

    task automatic test_simultaneous();
        logic [32:0] wa, wb, wc;
        wa = model_pack(3'd0, 7'h13, 5'd10, 5'd11, 5'd0, 3'd7, 32'd2047);
        wb = model_pack(3'd2, 7'h63, 5'd0, 5'd12, 5'd13, 3'd1, 32'd4094);
        wc = model_pack(3'd3, 7'h6F, 5'd14, 5'd0, 5'd0, 3'd0, 32'hFFF00000);
        @(negedge clk);
        out_ready = 1'b1;
        set_req(3'd0, 7'h13, 5'd10, 5'd11, 5'd0, 3'd7, 32'd2047);
        in_valid = 1'b1;
        @(negedge clk);
        set_req(3'd2, 7'h63, 5'd0, 5'd12, 5'd13, 3'd1, 32'd4094);
        #1;
        tests++; if (out_instr !== wa[31:0] || in_ready !== 1'b1) begin fails++; $display("FAIL sim_a got %h/%b want %h/1", out_instr, in_ready, wa[31:0]); end
        @(negedge clk);
        set_req(3'd3, 7'h6F, 5'd14, 5'd0, 5'd0, 3'd0, 32'hFFF00000);
        #1;
        tests++; if (out_valid !== 1'b1 || out_instr !== wb[31:0] || in_ready !== 1'b1) begin fails++; $display("FAIL sim_b got %b/%h/%b want 1/%h/1", out_valid, out_instr, in_ready, wb[31:0]); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++; if (out_instr !== wc[31:0] || out_err !== wc[32]) begin fails++; $display("FAIL sim_c got %h/%b want %h/%b", out_instr, out_err, wc[31:0], wc[32]); end
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sim_empty got %b want 0", out_valid); end
        $display("[TB] simultaneous accept/drain %h %h %h", wa[31:0], wb[31:0], wc[31:0]);
    endtask

    task automatic test_illegal();
        logic exp_e;
`ifdef INSTR_PACKER_RANGE_CHECK_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        @(negedge clk);
        out_ready = 1'b1;
        set_req(3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd4, 32'h12345678);
        in_valid = 1'b1;
        @(negedge clk);
        set_req(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
        #1;
        tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL illegal_instr got %h want 0", out_instr); end
        tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL illegal_err got %b want 1", out_err); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++; if (out_instr !== 32'h80000093) begin fails++; $display("FAIL range_instr got %h want 80000093", out_instr); end
        tests++; if (out_err !== exp_e) begin fails++; $display("FAIL range_err got %b want %b", out_err, exp_e); end
        @(negedge clk);
        $display("[TB] illegal sel and imm=0x800 checked");
    endtask

    task automatic test_random();
        logic [32:0] q [$];
        logic [31:0] qi [$];
        logic [2:0]  qs [$];
        logic        qrt [$];
        logic [2:0]  s;
        logic [31:0] im;
        logic        rdy_s, vld_s, acc, drn;
        int          r;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 15);
                s = (r < 14) ? 3'(r % 5) : 3'(r - 9);
                case ($urandom_range(0, 2))
                    0:       im = 32'($urandom_range(0, 8191)) - 32'd4096;
                    1:       im = $urandom;
                    default: im = $urandom & 32'hFFFFF000;
                endcase
                set_req(s, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), im);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            rdy_s = in_ready;
            vld_s = out_valid;
            tests++; if (out_valid !== (q.size() != 0)) begin fails++; $display("FAIL rand_valid c%0d got %b want %b", c, out_valid, q.size() != 0); end
            tests++; if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rand_ready c%0d got %b want %b", c, in_ready, q.size() < 2); end
            if (q.size() != 0) begin
                tests++;
                if (out_instr !== q[0][31:0] || out_err !== q[0][32]) begin
                    fails++; $display("FAIL rand_word c%0d got %h/%b want %h/%b", c, out_instr, out_err, q[0][31:0], q[0][32]);
                end
                if (qrt[0] && out_err === 1'b0) begin
                    tests++;
                    if (immgen(qs[0], out_instr) !== qi[0]) begin
                        fails++; $display("FAIL rand_roundtrip c%0d got %h want %h", c, immgen(qs[0], out_instr), qi[0]);
                    end
                end
            end
            acc = in_valid && rdy_s;
            drn = vld_s && out_ready;
            @(posedge clk);
            if (drn && q.size() != 0) begin
                void'(q.pop_front()); void'(qi.pop_front()); void'(qs.pop_front()); void'(qrt.pop_front());
            end
            if (acc) begin
                s = imm_sel;
                q.push_back(model_pack(s, opcode, rd, rs1, rs2, funct3, imm));
                qi.push_back(imm);
                qs.push_back(s);
                qrt.push_back((s <= 3'd4) && model_range_ok(s, imm));
            end
        end
        $display("[TB] random traffic done, %0d left in model", q.size());
    endtask

    task automatic test_reset_full();
        @(negedge clk);
        out_ready = 1'b0;
        set_req(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 32'h55555000);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL rstfull_pre got %b/%b want 0/1", in_ready, out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstfull_async_valid got %b want 0", out_valid); end
        tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL rstfull_async_instr got %h want 0", out_instr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rstfull_after got %b/%b want 1/0", in_ready, out_valid); end
        $display("[TB] reset while full checked");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_latency();
        test_formats();
        test_backpressure();
        test_simultaneous();
        test_illegal();
        test_random();
        test_reset_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
